// File: rtl/eth_udp_tx_framer.sv
// eth_udp_tx_framer
//   Feeds the RMII transmit stage's byte FIFO with one complete IPv4/UDP frame.
//   A user payload is buffered, the IPv4 header checksum is computed, then
//   header + payload + zero pad (minimum 46 bytes) are written out as one
//   contiguous burst. Eth_Pkt_Rdy then starts the transmit stage, and the next
//   frame is held off until that frame has left the wire (Tx_En high, then low).
//
// Ports
//   Clk, Rst        clock, synchronous active-high reset (shared with tx stage)
//   In_Byte/In_Valid/In_Last/In_Ready   payload input stream (valid/ready)
//   Tx_En           tx stage wire-active flag
//   Eth_Byte/Eth_Byte_Valid             FIFO write data / write strobe
//   Eth_Pkt_Rdy     one-cycle pulse after the last FIFO write
//   Busy            high whenever the framer is not idle
//   Trunc_Err       one-cycle pulse when the payload exceeded MAX_PAYLOAD
module eth_udp_tx_framer #(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter logic [31:0] SRC_IP      = 32'hC0A80002,
  parameter logic [31:0] DST_IP      = 32'hC0A800FF,
  parameter logic [15:0] SRC_PORT    = 16'h04D2,
  parameter logic [15:0] DST_PORT    = 16'h162E,
  parameter logic [7:0]  TTL         = 8'd64
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] In_Byte,
  input  logic       In_Valid,
  input  logic       In_Last,
  output logic       In_Ready,
  input  logic       Tx_En,
  output logic [7:0] Eth_Byte,
  output logic       Eth_Byte_Valid,
  output logic       Eth_Pkt_Rdy,
  output logic       Busy,
  output logic       Trunc_Err
);

  localparam int unsigned PW      = $clog2(MAX_PAYLOAD);
  localparam logic [15:0] HDR_LEN = 16'd28;
  localparam logic [15:0] MIN_LEN = 16'd46;

  typedef enum logic [3:0] {
    IDLE, CAPTURE, DRAIN, CSUM, HDR, PAYLOAD, PAD, KICK, WAIT_TX
  } state_t;

  state_t        state, stateNext;

  logic [7:0]    payloadMem [MAX_PAYLOAD];
  logic [PW:0]   payloadLen;
  logic [PW-1:0] rdPtr, rdPtrNext;
  logic [7:0]    rdData;
  logic [15:0]   ipId;
  logic [15:0]   csumAcc, csum;
  logic [15:0]   byteCnt;
  logic [3:0]    wordCnt;
  logic          txSeen;

  logic          accept, lastAccept, wrEn, overflow, emit;
  logic [7:0]    byteNext;
  logic [15:0]   totLen, udpLen, hdrW, csumW, csumFold;
  logic [16:0]   csumSum;

  // Header word idx (0..13): ten IPv4 words then four UDP words.
  function automatic logic [15:0] hdrWord(
    input logic [3:0]  idx,
    input logic [15:0] tot,
    input logic [15:0] id,
    input logic [15:0] udp,
    input logic [15:0] csumField
  );
    case (idx)
      4'd0:    hdrWord = 16'h4500;
      4'd1:    hdrWord = tot;
      4'd2:    hdrWord = id;
      4'd3:    hdrWord = 16'h4000;
      4'd4:    hdrWord = {TTL, 8'h11};
      4'd5:    hdrWord = csumField;
      4'd6:    hdrWord = SRC_IP[31:16];
      4'd7:    hdrWord = SRC_IP[15:0];
      4'd8:    hdrWord = DST_IP[31:16];
      4'd9:    hdrWord = DST_IP[15:0];
      4'd10:   hdrWord = SRC_PORT;
      4'd11:   hdrWord = DST_PORT;
      4'd12:   hdrWord = udp;
      default: hdrWord = 16'h0000;
    endcase
  endfunction

  assign In_Ready = (state == IDLE) || (state == CAPTURE) || (state == DRAIN);
  assign Busy     = (state != IDLE);

  assign totLen = HDR_LEN + 16'(payloadLen);
  assign udpLen = 16'd8 + 16'(payloadLen);

  // Ones-complement accumulation; a single fold suffices because the
  // accumulator never exceeds 0xFFFF, so the folded sum cannot carry again.
  assign csumW    = hdrWord(wordCnt, totLen, ipId, udpLen, 16'h0000);
  assign csumSum  = {1'b0, csumAcc} + {1'b0, csumW};
  assign csumFold = csumSum[15:0] + {15'd0, csumSum[16]};

  assign hdrW = hdrWord(byteCnt[4:1], totLen, ipId, udpLen, csum);

  always_comb begin
    stateNext  = state;
    accept     = In_Valid & In_Ready;
    lastAccept = accept & In_Last;
    wrEn       = 1'b0;
    overflow   = 1'b0;
    emit       = 1'b0;
    byteNext   = '0;
    rdPtrNext  = rdPtr;
    case (state)
      IDLE, CAPTURE: begin
        wrEn = accept;
        if (lastAccept) begin
          stateNext = CSUM;
        end else if (accept) begin
          if (payloadLen == (PW+1)'(MAX_PAYLOAD - 1)) begin
            overflow  = 1'b1;
            stateNext = DRAIN;
          end else begin
            stateNext = CAPTURE;
          end
        end
      end
      DRAIN: begin
        if (lastAccept) stateNext = CSUM;
      end
      CSUM: begin
        if (wordCnt == 4'd9) stateNext = HDR;
      end
      HDR: begin
        emit     = 1'b1;
        byteNext = byteCnt[0] ? hdrW[7:0] : hdrW[15:8];
        if (byteCnt == HDR_LEN - 16'd1) stateNext = PAYLOAD;
      end
      PAYLOAD: begin
        emit      = 1'b1;
        byteNext  = rdData;
        rdPtrNext = rdPtr + 1'b1;
        if (byteCnt == totLen - 16'd1) begin
          stateNext = (totLen < MIN_LEN) ? PAD : KICK;
        end
      end
      PAD: begin
        emit = 1'b1;
        if (byteCnt == MIN_LEN - 16'd1) stateNext = KICK;
      end
      KICK: begin
        stateNext = WAIT_TX;
      end
      WAIT_TX: begin
        if (txSeen && !Tx_En) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (lastAccept) rdPtrNext = '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= IDLE;
      payloadLen     <= '0;
      rdPtr          <= '0;
      ipId           <= '0;
      csumAcc        <= '0;
      csum           <= '0;
      byteCnt        <= '0;
      wordCnt        <= '0;
      txSeen         <= 1'b0;
      Eth_Byte       <= '0;
      Eth_Byte_Valid <= 1'b0;
      Eth_Pkt_Rdy    <= 1'b0;
      Trunc_Err      <= 1'b0;
    end else begin
      state          <= stateNext;
      rdPtr          <= rdPtrNext;
      Eth_Byte       <= byteNext;
      Eth_Byte_Valid <= emit;
      Eth_Pkt_Rdy    <= (state == KICK);
      Trunc_Err      <= overflow;

      if (wrEn) payloadLen <= payloadLen + 1'b1;

      if (lastAccept) begin
        csumAcc <= '0;
        wordCnt <= '0;
        byteCnt <= '0;
        txSeen  <= 1'b0;
      end

      if (state == CSUM) begin
        csumAcc <= csumFold;
        wordCnt <= wordCnt + 4'd1;
        if (wordCnt == 4'd9) csum <= ~csumFold;
      end

      if (emit) byteCnt <= byteCnt + 16'd1;

      if (state == KICK) ipId <= ipId + 16'd1;

      if (state == WAIT_TX) begin
        if (Tx_En) txSeen <= 1'b1;
        if (stateNext == IDLE) begin
          payloadLen <= '0;
          txSeen     <= 1'b0;
        end
      end
    end
  end

  // Buffer reads are re-issued every cycle from the next pointer, so rdData
  // always holds payloadMem[rdPtr]; the first payload byte is therefore ready
  // when the header ends and a write of byte 0 during capture is picked up.
  always_ff @(posedge Clk) begin
    if (wrEn) payloadMem[payloadLen[PW-1:0]] <= In_Byte;
    rdData <= payloadMem[rdPtrNext];
  end

endmodule

// File: tb/tb_eth_udp_tx_framer.sv
module tb_eth_udp_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] In_Byte;
  logic       In_Valid;
  logic       In_Last;
  logic       In_Ready;
  logic       Tx_En;
  logic [7:0] Eth_Byte;
  logic       Eth_Byte_Valid;
  logic       Eth_Pkt_Rdy;
  logic       Busy;
  logic       Trunc_Err;

  always #5 Clk = ~Clk;

  eth_udp_tx_framer #(
    .MAX_PAYLOAD(64),
    .SRC_IP(32'hC0A80002),
    .DST_IP(32'hC0A800FF),
    .SRC_PORT(16'h04D2),
    .DST_PORT(16'h162E),
    .TTL(8'd64)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .In_Byte(In_Byte),
    .In_Valid(In_Valid),
    .In_Last(In_Last),
    .In_Ready(In_Ready),
    .Tx_En(Tx_En),
    .Eth_Byte(Eth_Byte),
    .Eth_Byte_Valid(Eth_Byte_Valid),
    .Eth_Pkt_Rdy(Eth_Pkt_Rdy),
    .Busy(Busy),
    .Trunc_Err(Trunc_Err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  expQ[$];
  int          lenQ[$];
  int          truncQ[$];
  bit          monEn = 1'b0;
  int          sentCnt = 0;
  int          doneCnt = 0;
  logic [15:0] modelId = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame built straight from the IPv4/UDP field layout.
  task automatic pushModel(input logic [7:0] pl[$]);
    logic [15:0] w[14];
    int unsigned sum;
    int n, total;
    n = (pl.size() > 64) ? 64 : pl.size();
    w[0] = 16'h4500;       w[1] = 16'(28 + n);     w[2] = modelId;
    w[3] = 16'h4000;       w[4] = 16'h4011;        w[5] = 16'h0000;
    w[6] = 16'hC0A8;       w[7] = 16'h0002;        w[8] = 16'hC0A8;
    w[9] = 16'h00FF;       w[10] = 16'h04D2;       w[11] = 16'h162E;
    w[12] = 16'(8 + n);    w[13] = 16'h0000;
    sum = 0;
    for (int i = 0; i < 10; i++) sum += w[i];
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    w[5] = ~sum[15:0];
    for (int i = 0; i < 14; i++) begin
      expQ.push_back(w[i][15:8]);
      expQ.push_back(w[i][7:0]);
    end
    for (int i = 0; i < n; i++) expQ.push_back(pl[i]);
    total = 28 + n;
    while (total < 46) begin
      expQ.push_back(8'h00);
      total++;
    end
    lenQ.push_back(total);
    truncQ.push_back((pl.size() > 64) ? 1 : 0);
    modelId++;
  endtask

  task automatic makeRandom(output logic [7:0] pl[$], input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic sendFrame(input logic [7:0] pl[$]);
    for (int i = 0; i < pl.size(); i++) begin
      int unsigned guard;
      bit done;
      logic rdy;
      guard = 0;
      done  = 1'b0;
      while (!done) begin
        In_Valid = 1'b1;
        In_Byte  = pl[i];
        In_Last  = (i == pl.size() - 1);
        @(negedge Clk);
        rdy = In_Ready;
        @(posedge Clk);
        #1;
        if (rdy) done = 1'b1;
        else begin
          guard++;
          if (guard > 4000) begin
            check("accept_timeout", guard, 0);
            done = 1'b1;
          end
        end
      end
      In_Valid = 1'b0;
      In_Last  = 1'($urandom);
      In_Byte  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge Clk);
        #1;
      end
    end
    In_Last = 1'b0;
    sentCnt++;
  endtask

  task automatic drain();
    int unsigned cyc;
    cyc = 0;
    while ((expQ.size() != 0 || lenQ.size() != 0 || sentCnt != doneCnt) && cyc < 20000) begin
      @(posedge Clk);
      cyc++;
    end
    check("drain_complete", (expQ.size() == 0 && lenQ.size() == 0 && sentCnt == doneCnt), 1);
  endtask

  // Transmit-stage stand-in: after each kick, raise Tx_En for a while.
  initial begin : txEmu
    Tx_En = 1'b0;
    forever begin
      @(negedge Clk);
      if (Eth_Pkt_Rdy && !Rst) begin
        repeat ($urandom_range(1, 4)) @(posedge Clk);
        #1 Tx_En = 1'b1;
        repeat ($urandom_range(1, 12)) @(posedge Clk);
        #1 Tx_En = 1'b0;
        @(posedge Clk);
        #1 doneCnt++;
      end
    end
  end

  initial begin : monitor
    int runLen;
    int truncSeen;
    bit prevValid;
    runLen = 0;
    truncSeen = 0;
    prevValid = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        runLen = 0;
        truncSeen = 0;
        prevValid = 1'b0;
      end else if (monEn) begin
        if (Eth_Byte_Valid) begin
          if (runLen != 0) check("contiguous_writes", prevValid, 1);
          check("expected_byte_pending", (expQ.size() != 0), 1);
          if (expQ.size() != 0) check("eth_byte", Eth_Byte, expQ.pop_front());
          runLen++;
        end
        if (Trunc_Err) truncSeen++;
        if (Eth_Pkt_Rdy) begin
          check("pkt_rdy_follows_last_write", prevValid, 1);
          check("expected_frame_pending", (lenQ.size() != 0), 1);
          if (lenQ.size() != 0) begin
            check("frame_len", runLen, lenQ.pop_front());
            check("trunc_count", truncSeen, truncQ.pop_front());
          end
          runLen = 0;
          truncSeen = 0;
        end
        if (sentCnt != doneCnt) check("in_ready_low_while_framing", In_Ready, 0);
        prevValid = Eth_Byte_Valid;
      end
    end
  end

  initial begin : main
    logic [7:0] pl[$];
    logic [7:0] hdr1[28];
    int lens[7];
    int cnt;
    int unsigned cyc;

    Rst = 1'b1;
    In_Valid = 1'b0;
    In_Last = 1'b0;
    In_Byte = 8'h00;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_in_ready", In_Ready, 1);
    check("rst_busy", Busy, 0);
    check("rst_valid", Eth_Byte_Valid, 0);
    check("rst_byte", Eth_Byte, 0);
    check("rst_pkt_rdy", Eth_Pkt_Rdy, 0);
    check("rst_trunc", Trunc_Err, 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    monEn = 1'b1;

    // Frame 1 against the literal reference bytes (ID 0, N=4).
    hdr1 = '{8'h45, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
             8'hB8, 8'h7B, 8'hC0, 8'hA8, 8'h00, 8'h02, 8'hC0, 8'hA8, 8'h00, 8'hFF,
             8'h04, 8'hD2, 8'h16, 8'h2E, 8'h00, 8'h0C, 8'h00, 8'h00};
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 28; i++) expQ.push_back(hdr1[i]);
    for (int i = 0; i < 4; i++) expQ.push_back(pl[i]);
    for (int i = 0; i < 14; i++) expQ.push_back(8'h00);
    lenQ.push_back(46);
    truncQ.push_back(0);
    modelId = 16'd1;
    sendFrame(pl);

    // Back-to-back frames: later bytes are offered while the framer waits on Tx_En.
    lens = '{18, 70, 1, 17, 63, 64, 65};
    for (int k = 0; k < 7; k++) begin
      makeRandom(pl, lens[k]);
      pushModel(pl);
      sendFrame(pl);
    end
    for (int k = 0; k < 6; k++) begin
      makeRandom(pl, int'($urandom_range(1, 90)));
      pushModel(pl);
      sendFrame(pl);
    end
    drain();

    // Reset in the middle of the header burst.
    monEn = 1'b0;
    makeRandom(pl, 10);
    sendFrame(pl);
    cnt = 0;
    cyc = 0;
    while (cnt < 5 && cyc < 1000) begin
      @(negedge Clk);
      if (Eth_Byte_Valid) cnt++;
      cyc++;
    end
    check("reached_header", cnt, 5);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_valid", Eth_Byte_Valid, 0);
    check("midrst_byte", Eth_Byte, 0);
    check("midrst_pkt_rdy", Eth_Pkt_Rdy, 0);
    check("midrst_trunc", Trunc_Err, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_in_ready", In_Ready, 1);
    @(posedge Clk);
    #1 Rst = 1'b0;
    sentCnt--;
    modelId = 16'd0;
    monEn = 1'b1;

    makeRandom(pl, 5);
    pushModel(pl);
    sendFrame(pl);
    drain();

    repeat (5) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
